// File: rtl/rv32i_pipe_pkg.sv
// Shared types and constants for the RV32I pipeline control blocks.
package rv32i_pipe_pkg;

  localparam int unsigned XLEN_D   = 32;
  localparam int unsigned REG_AW_D = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;

  // Per-stage shadow of the destination/source information travelling with an instruction.
  typedef struct packed {
    logic                valid;
    logic [REG_AW_D-1:0] rd;
    logic [REG_AW_D-1:0] rs1;
    logic [REG_AW_D-1:0] rs2;
    logic                use_rs1;
    logic                use_rs2;
    logic                reg_write;
    logic                mem_read;
  } stage_rec_t;

endpackage

// File: rtl/rv32i_fwd_mux.sv
// Operand forwarding for one EX source: producer selection plus the 3:1 data mux.
module rv32i_fwd_mux
  import rv32i_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_D,
  parameter int unsigned REG_AW = REG_AW_D
) (
  input  logic              ex_valid,
  input  logic              use_rs,
  input  logic [REG_AW-1:0] rs,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   regfile_data,
  input  logic [XLEN-1:0]   exmem_data,
  input  logic [XLEN-1:0]   memwb_data,
  output logic [1:0]        sel_c,
  output logic [XLEN-1:0]   op_c
);

  logic mem_hit;
  logic wb_hit;

  // A load in MEM has no data yet, so only ALU producers forward from EX/MEM.
  assign mem_hit = mem_valid && mem_reg_write && !mem_mem_read &&
                   (mem_rd != '0) && (mem_rd == rs);
  assign wb_hit  = wb_valid && wb_reg_write && (wb_rd != '0) && (wb_rd == rs);

  always_comb begin
    sel_c = FWD_REGFILE;
    if (ex_valid && use_rs) begin
      if (mem_hit) begin
        sel_c = FWD_EXMEM;
      end else if (wb_hit) begin
        sel_c = FWD_MEMWB;
      end
    end
  end

  always_comb begin
    op_c = regfile_data;
    case (sel_c)
      FWD_EXMEM: op_c = exmem_data;
      FWD_MEMWB: op_c = memwb_data;
      default:   op_c = regfile_data;
    endcase
  end

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Hazard, forwarding and stall control for the 5-stage RV32I pipeline,
// with saturating stall/flush performance counters.
module rv32i_hazard_ctrl
  import rv32i_pipe_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_D,
  parameter int unsigned REG_AW       = REG_AW_D,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned PERF_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  input  logic [XLEN-1:0]   ex_rs1_data,
  input  logic [XLEN-1:0]   ex_rs2_data,
  input  logic [XLEN-1:0]   exmem_alu_result,
  input  logic [XLEN-1:0]   wb_data,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              mem_stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [XLEN-1:0]   ex_op_a,
  output logic [XLEN-1:0]   ex_op_b,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  localparam int unsigned WAIT_W = 3;

  stage_rec_t        ex_q;
  stage_rec_t        mem_q;
  stage_rec_t        wb_q;
  stage_rec_t        id_rec;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              unused_rec;

  // ID record as it would enter EX; a bubble enters as an invalid slot.
  always_comb begin
    id_rec           = '0;
    id_rec.valid     = id_valid && !id_ex_bubble;
    id_rec.rd        = REG_AW_D'(id_rd);
    id_rec.rs1       = REG_AW_D'(id_rs1);
    id_rec.rs2       = REG_AW_D'(id_rs2);
    id_rec.use_rs1   = id_use_rs1;
    id_rec.use_rs2   = id_use_rs2;
    id_rec.reg_write = id_reg_write;
    id_rec.mem_read  = id_mem_read;
  end

  assign mem_stall = mem_q.valid && mem_q.mem_read &&
                     (wait_cnt != WAIT_W'(LOAD_LATENCY - 1));

  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                    ((id_use_rs1 && (REG_AW_D'(id_rs1) == ex_q.rd)) ||
                     (id_use_rs2 && (REG_AW_D'(id_rs2) == ex_q.rd)));

  // Enable/flush priority: memory freeze, then taken branch, then load-use.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!mem_stall) begin
      ex_q  <= id_rec;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (mem_stall) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + PERF_W'(1);
      end
      if (if_id_flush && (flush_count != '1)) begin
        flush_count <= flush_count + PERF_W'(1);
      end
    end
  end

  rv32i_fwd_mux #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwd_a (
    .ex_valid      (ex_q.valid),
    .use_rs        (ex_q.use_rs1),
    .rs            (REG_AW'(ex_q.rs1)),
    .mem_valid     (mem_q.valid),
    .mem_reg_write (mem_q.reg_write),
    .mem_mem_read  (mem_q.mem_read),
    .mem_rd        (REG_AW'(mem_q.rd)),
    .wb_valid      (wb_q.valid),
    .wb_reg_write  (wb_q.reg_write),
    .wb_rd         (REG_AW'(wb_q.rd)),
    .regfile_data  (ex_rs1_data),
    .exmem_data    (exmem_alu_result),
    .memwb_data    (wb_data),
    .sel_c         (fwd_a_sel),
    .op_c          (ex_op_a)
  );

  rv32i_fwd_mux #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwd_b (
    .ex_valid      (ex_q.valid),
    .use_rs        (ex_q.use_rs2),
    .rs            (REG_AW'(ex_q.rs2)),
    .mem_valid     (mem_q.valid),
    .mem_reg_write (mem_q.reg_write),
    .mem_mem_read  (mem_q.mem_read),
    .mem_rd        (REG_AW'(mem_q.rd)),
    .wb_valid      (wb_q.valid),
    .wb_reg_write  (wb_q.reg_write),
    .wb_rd         (REG_AW'(wb_q.rd)),
    .regfile_data  (ex_rs2_data),
    .exmem_data    (exmem_alu_result),
    .memwb_data    (wb_data),
    .sel_c         (fwd_b_sel),
    .op_c          (ex_op_b)
  );

  // Record fields carried for pipeline visibility but not consumed by this stage logic.
  assign unused_rec = ^{ex_q.reg_write, mem_q.rs1, mem_q.rs2, mem_q.use_rs1, mem_q.use_rs2,
                        wb_q.rs1, wb_q.rs2, wb_q.use_rs1, wb_q.use_rs2, wb_q.mem_read};

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Bench for rv32i_hazard_ctrl: three latency/counter-width variants driven in parallel,
// each compared every cycle against an instruction-level pipeline model.
module tb_rv32i_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic        ex_branch_taken;
  logic [31:0] ex_rs1_data, ex_rs2_data, exmem_alu_result, wb_data;

  logic        d_pcw [3];
  logic        d_ifw [3];
  logic        d_bub [3];
  logic        d_fl [3];
  logic        d_stall [3];
  logic [1:0]  d_sa [3];
  logic [1:0]  d_sb [3];
  logic [31:0] d_oa [3];
  logic [31:0] d_ob [3];
  logic [3:0]  sc0, fc0;
  logic [31:0] sc1, fc1, sc2, fc2;

  int n_checks = 0;
  int n_pass   = 0;

  rv32i_hazard_ctrl #(.LOAD_LATENCY(1), .PERF_W(4)) u_ll1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .exmem_alu_result(exmem_alu_result),
    .wb_data(wb_data), .pc_write(d_pcw[0]), .if_id_write(d_ifw[0]), .id_ex_bubble(d_bub[0]),
    .if_id_flush(d_fl[0]), .mem_stall(d_stall[0]), .fwd_a_sel(d_sa[0]), .fwd_b_sel(d_sb[0]),
    .ex_op_a(d_oa[0]), .ex_op_b(d_ob[0]), .stall_cycles(sc0), .flush_count(fc0));

  rv32i_hazard_ctrl #(.LOAD_LATENCY(3)) u_ll3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .exmem_alu_result(exmem_alu_result),
    .wb_data(wb_data), .pc_write(d_pcw[1]), .if_id_write(d_ifw[1]), .id_ex_bubble(d_bub[1]),
    .if_id_flush(d_fl[1]), .mem_stall(d_stall[1]), .fwd_a_sel(d_sa[1]), .fwd_b_sel(d_sb[1]),
    .ex_op_a(d_oa[1]), .ex_op_b(d_ob[1]), .stall_cycles(sc1), .flush_count(fc1));

  rv32i_hazard_ctrl #(.LOAD_LATENCY(4)) u_ll4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .exmem_alu_result(exmem_alu_result),
    .wb_data(wb_data), .pc_write(d_pcw[2]), .if_id_write(d_ifw[2]), .id_ex_bubble(d_bub[2]),
    .if_id_flush(d_fl[2]), .mem_stall(d_stall[2]), .fwd_a_sel(d_sa[2]), .fwd_b_sel(d_sb[2]),
    .ex_op_a(d_oa[2]), .ex_op_b(d_ob[2]), .stall_cycles(sc2), .flush_count(fc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an instruction slot per stage plus how long the MEM slot has waited.
  typedef struct packed {
    logic       v;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, rw, mr;
  } ent_t;

  typedef struct packed {
    logic        stall, pcw, ifw, bub, fl;
    logic [1:0]  sa, sb;
    logic [31:0] oa, ob;
  } mo_t;

  ent_t            m_ex [3];
  ent_t            m_mem [3];
  ent_t            m_wb [3];
  int              m_age [3];
  longint unsigned m_sc [3];
  longint unsigned m_fc [3];
  int              ll_tab [3] = '{1, 3, 4};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic longint unsigned cmax(int k);
    return (k == 0) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] dut_sc(int k);
    case (k)
      0:       return 32'(sc0);
      1:       return sc1;
      default: return sc2;
    endcase
  endfunction

  function automatic logic [31:0] dut_fc(int k);
    case (k)
      0:       return 32'(fc0);
      1:       return fc1;
      default: return fc2;
    endcase
  endfunction

  // Youngest non-load producer of a source register wins; x0 never forwards.
  function automatic logic [1:0] src(int k, logic [4:0] rs, logic use_rs);
    if (!m_ex[k].v || !use_rs) return 2'b00;
    if (m_mem[k].v && m_mem[k].rw && !m_mem[k].mr && m_mem[k].rd != 0 && m_mem[k].rd == rs)
      return 2'b10;
    if (m_wb[k].v && m_wb[k].rw && m_wb[k].rd != 0 && m_wb[k].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic mo_t model_out(int k);
    mo_t  o;
    logic lu;
    o = '0;
    o.stall = m_mem[k].v && m_mem[k].mr && (m_age[k] < ll_tab[k] - 1);
    lu = m_ex[k].v && m_ex[k].mr && m_ex[k].rd != 0 && id_valid &&
         ((id_use_rs1 && id_rs1 == m_ex[k].rd) || (id_use_rs2 && id_rs2 == m_ex[k].rd));
    if (o.stall) begin
      o.pcw = 0; o.ifw = 0;
    end else if (ex_branch_taken) begin
      o.pcw = 1; o.ifw = 1; o.fl = 1; o.bub = 1;
    end else if (lu) begin
      o.bub = 1;
    end else begin
      o.pcw = 1; o.ifw = 1;
    end
    o.sa = src(k, m_ex[k].rs1, m_ex[k].u1);
    o.sb = src(k, m_ex[k].rs2, m_ex[k].u2);
    o.oa = (o.sa == 2'b10) ? exmem_alu_result : (o.sa == 2'b01) ? wb_data : ex_rs1_data;
    o.ob = (o.sb == 2'b10) ? exmem_alu_result : (o.sb == 2'b01) ? wb_data : ex_rs2_data;
    return o;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
      m_age[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  task automatic model_next(int k);
    mo_t  o;
    ent_t e;
    o = model_out(k);
    if (!o.pcw && m_sc[k] < cmax(k)) m_sc[k]++;
    if (o.fl && m_fc[k] < cmax(k)) m_fc[k]++;
    if (o.stall) begin
      m_age[k]++;
    end else begin
      e = '{v: id_valid && !o.bub, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
            u1: id_use_rs1, u2: id_use_rs2, rw: id_reg_write, mr: id_mem_read};
      m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = e;
      m_age[k] = 0;
    end
  endtask

  task automatic check_all();
    mo_t o;
    #1;
    for (int k = 0; k < 3; k++) begin
      o = model_out(k);
      check($sformatf("i%0d_mem_stall", k), 64'(d_stall[k]), 64'(o.stall));
      check($sformatf("i%0d_pc_write", k), 64'(d_pcw[k]), 64'(o.pcw));
      check($sformatf("i%0d_if_id_write", k), 64'(d_ifw[k]), 64'(o.ifw));
      check($sformatf("i%0d_bubble", k), 64'(d_bub[k]), 64'(o.bub));
      check($sformatf("i%0d_flush", k), 64'(d_fl[k]), 64'(o.fl));
      check($sformatf("i%0d_fwd_a_sel", k), 64'(d_sa[k]), 64'(o.sa));
      check($sformatf("i%0d_fwd_b_sel", k), 64'(d_sb[k]), 64'(o.sb));
      check($sformatf("i%0d_ex_op_a", k), 64'(d_oa[k]), 64'(o.oa));
      check($sformatf("i%0d_ex_op_b", k), 64'(d_ob[k]), 64'(o.ob));
      check($sformatf("i%0d_stall_cycles", k), 64'(dut_sc(k)), m_sc[k]);
      check($sformatf("i%0d_flush_count", k), 64'(dut_fc(k)), m_fc[k]);
    end
  endtask

  task automatic advance();
    for (int k = 0; k < 3; k++) model_next(k);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    ex_rs1_data      = $urandom;
    ex_rs2_data      = $urandom;
    exmem_alu_result = $urandom;
    wb_data          = $urandom;
  endtask

  task automatic drive_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    rand_data();
  endtask

  task automatic drive_nop();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; ex_branch_taken = 0;
    rand_data();
  endtask

  task automatic do_reset();
    drive_nop();
    reset = 0;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1;
    check_all();
  endtask

  int stall_n [3];

  initial begin
    reset = 0;
    drive_nop();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    check_all();
    check("rst_pc_write", 64'(d_pcw[0]), 64'd1);
    check("rst_if_id_write", 64'(d_ifw[0]), 64'd1);
    check("rst_bubble", 64'(d_bub[0]), 64'd0);
    check("rst_flush", 64'(d_fl[0]), 64'd0);
    check("rst_mem_stall", 64'(d_stall[2]), 64'd0);
    check("rst_fwd_a_sel", 64'(d_sa[1]), 64'd0);
    check("rst_counters", 64'({sc1, fc1}), 64'd0);

    // lw x5,0(x1); add x6,x5,x2
    drive_id(5'd1, 5'd0, 1, 0, 5'd5, 1, 1); check_all(); advance();
    drive_id(5'd5, 5'd2, 1, 1, 5'd6, 1, 0); check_all();
    check("lu_pc_write", 64'(d_pcw[0]), 64'd0);
    check("lu_bubble", 64'(d_bub[0]), 64'd1);
    advance();
    drive_id(5'd5, 5'd2, 1, 1, 5'd6, 1, 0); check_all();
    check("lu_release", 64'(d_pcw[0]), 64'd1);
    advance();
    drive_nop(); check_all();
    check("lu_fwd_a_sel", 64'(d_sa[0]), 64'b01);
    check("lu_ex_op_a", 64'(d_oa[0]), 64'(wb_data));
    check("lu_stall_cycles", 64'(sc0), 64'd1);
    advance();

    // add x3,x1,x2; sub x4,x3,x3
    do_reset();
    drive_id(5'd1, 5'd2, 1, 1, 5'd3, 1, 0); check_all(); advance();
    drive_id(5'd3, 5'd3, 1, 1, 5'd4, 1, 0); check_all(); advance();
    drive_nop(); check_all();
    check("alu_fwd_a_sel", 64'(d_sa[1]), 64'b10);
    check("alu_fwd_b_sel", 64'(d_sb[1]), 64'b10);
    check("alu_ex_op_a", 64'(d_oa[1]), 64'(exmem_alu_result));
    check("alu_no_stall", 64'(d_pcw[1]), 64'd1);
    advance();

    // addi x0,x0,5; add x7,x0,x0
    do_reset();
    drive_id(5'd0, 5'd0, 1, 0, 5'd0, 1, 0); check_all(); advance();
    drive_id(5'd0, 5'd0, 1, 1, 5'd7, 1, 0); check_all(); advance();
    drive_nop();
    exmem_alu_result = 32'd5;
    ex_rs1_data = 32'h1234_5678;
    check_all();
    check("x0_fwd_a_sel", 64'(d_sa[0]), 64'b00);
    check("x0_fwd_b_sel", 64'(d_sb[0]), 64'b00);
    check("x0_ex_op_a", 64'(d_oa[0]), 64'h1234_5678);
    advance();

    // Taken branch in EX while ID has a load-use hazard
    do_reset();
    drive_id(5'd1, 5'd0, 1, 0, 5'd5, 1, 1); check_all(); advance();
    drive_id(5'd5, 5'd2, 1, 1, 5'd6, 1, 0);
    ex_branch_taken = 1;
    check_all();
    check("br_lu_flush", 64'(d_fl[0]), 64'd1);
    check("br_lu_bubble", 64'(d_bub[0]), 64'd1);
    check("br_lu_pc_write", 64'(d_pcw[0]), 64'd1);
    advance();
    drive_nop(); check_all();
    check("br_lu_flush_count", 64'(fc0), 64'd1);
    check("br_lu_stall_cycles", 64'(sc0), 64'd0);
    advance();

    // LOAD_LATENCY=3: lw then taken beq held in EX during the memory freeze
    do_reset();
    drive_id(5'd1, 5'd0, 1, 0, 5'd5, 1, 1); check_all(); advance();
    drive_id(5'd1, 5'd2, 1, 1, 5'd0, 0, 0); check_all(); advance();
    for (int c = 0; c < 3; c++) begin
      drive_nop();
      ex_branch_taken = 1;
      check_all();
      check($sformatf("ll3_stall_c%0d", c), 64'(d_stall[1]), (c < 2) ? 64'd1 : 64'd0);
      check($sformatf("ll3_flush_c%0d", c), 64'(d_fl[1]), (c < 2) ? 64'd0 : 64'd1);
      check($sformatf("ll3_pc_write_c%0d", c), 64'(d_pcw[1]), (c < 2) ? 64'd0 : 64'd1);
      check($sformatf("ll3_if_id_write_c%0d", c), 64'(d_ifw[1]), (c < 2) ? 64'd0 : 64'd1);
      advance();
    end

    // LOAD_LATENCY=4: asynchronous reset on the second stall cycle
    do_reset();
    drive_id(5'd1, 5'd0, 1, 0, 5'd5, 1, 1); check_all(); advance();
    drive_nop(); check_all(); advance();
    drive_nop(); check_all(); advance();
    drive_nop(); check_all();
    check("ll4_stall_before_rst", 64'(d_stall[2]), 64'd1);
    reset = 0;
    model_reset();
    check_all();
    check("ll4_async_stall", 64'(d_stall[2]), 64'd0);
    check("ll4_async_counters", 64'({sc2, fc2}), 64'd0);
    reset = 1;
    advance();
    drive_id(5'd1, 5'd0, 1, 0, 5'd5, 1, 1); check_all(); advance();
    for (int k = 0; k < 3; k++) stall_n[k] = 0;
    for (int c = 0; c < 12; c++) begin
      drive_nop(); check_all();
      for (int k = 0; k < 3; k++) if (d_stall[k]) stall_n[k]++;
      advance();
    end
    check("relaunch_ll1_stalls", 64'(stall_n[0]), 64'd0);
    check("relaunch_ll3_stalls", 64'(stall_n[1]), 64'd2);
    check("relaunch_ll4_stalls", 64'(stall_n[2]), 64'd3);
    check("relaunch_ll4_stall_cycles", 64'(sc2), 64'd3);

    // Randomised traffic over a small register window to provoke hazards
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
               1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom % 3 == 0));
      id_valid = ($urandom % 4) != 0;
      ex_branch_taken = ($urandom % 8) == 0;
      if ($urandom % 200 == 0) begin
        reset = 0;
        model_reset();
        #1;
        reset = 1;
      end
      check_all();
      advance();
    end

    // Counter saturation on the narrow-counter instance
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive_nop();
      ex_branch_taken = 1;
      check_all();
      advance();
    end
    drive_nop(); check_all();
    check("sat_flush_count_w4", 64'(fc0), 64'd15);
    check("sat_flush_count_w32", 64'(fc1), 64'd20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32i_hazard_ctrl.md
Name: rv32i_hazard_ctrl

Overview:
- Hazard, forwarding and stall controller for the 5-stage RV32I pipeline; fills the fixed pc_write/if_id_write=1 tie-offs and adds flush, bubble, forwarding and multi-cycle data-memory stall.
- Holds its own shadow copy of EX/MEM/WB destination state, advanced in lockstep with the pipeline registers.
- Drives IF/ID write enables, ID/EX bubble, IF/ID flush and EX operand muxing.
- Carries saturating performance counters.

Parameters:
- XLEN, 32, datapath width of forwarded operands.
- REG_AW, 5, register-address width.
- LOAD_LATENCY, 1, data-memory cycles per load (1..8); values above 1 freeze the pipeline.
- PERF_W, 32, width of performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; reset=0 clears all state.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  ID source registers.
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2.
- id_rd  in  REG_AW  ID destination.
- id_reg_write, id_mem_read  in  1  ID control.
- ex_branch_taken  in  1  EX branch resolved taken.
- ex_rs1_data, ex_rs2_data  in  XLEN  ID/EX register-file operands.
- exmem_alu_result  in  XLEN  EX/MEM ALU result.
- wb_data  in  XLEN  MEM/WB writeback value.
- pc_write, if_id_write  out  1  enables.
- id_ex_bubble  out  1  zero control into ID/EX.
- if_id_flush  out  1  squash IF/ID.
- mem_stall  out  1  freeze all pipeline registers.
- fwd_a_sel, fwd_b_sel  out  2  00 regfile, 10 EX/MEM, 01 MEM/WB.
- ex_op_a, ex_op_b  out  XLEN  forwarded operands.
- stall_cycles, flush_count  out  PERF_W  counters.

Behaviour:
- Shadow state, one record each for EX, MEM and WB: {valid, rd, rs1, rs2, use_rs1, use_rs2, reg_write, mem_read}. All cleared on reset.
- Advance rule:
  - If mem_stall=1, all records hold.
  - Otherwise EX <= ID info, with valid forced to 0 when id_ex_bubble=1; MEM <= EX; WB <= MEM.
- Memory wait counter wait_cnt, 3 bits, reset 0:
  - mem_stall = MEM.valid & MEM.mem_read & (wait_cnt != LOAD_LATENCY-1).
  - wait_cnt increments while mem_stall=1 and clears the cycle the load releases.
  - With LOAD_LATENCY=1, mem_stall is constantly 0.
- Load-use: lu = EX.valid & EX.mem_read & EX.rd!=0 & id_valid & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
- Output priority, first match wins:
  1. mem_stall: pc_write=0, if_id_write=0, bubble=0, flush=0. ex_branch_taken is ignored; it is re-presented when the branch is held in EX.
  2. ex_branch_taken: pc_write=1, if_id_write=1, flush=1, bubble=1. Overrides lu, because the ID instruction is squashed anyway.
  3. lu: pc_write=0, if_id_write=0, bubble=1, flush=0. Costs exactly one bubble.
  4. Otherwise: pc_write=1, if_id_write=1, bubble=0, flush=0.
- Forwarding for operand A (B is symmetric using rs2/use_rs2):
  - Select 10 if MEM.valid & MEM.reg_write & !MEM.mem_read & MEM.rd!=0 & EX.rs1==MEM.rd.
  - Else select 01 if WB.valid & WB.reg_write & WB.rd!=0 & EX.rs1==WB.rd.
  - Else select 00.
  - Select 00 whenever use_rs1=0 or EX.valid=0.
  - MEM beats WB, giving the youngest producer.
  - x0 is never forwarded.
- ex_op_a/ex_op_b are a combinational 3:1 mux on fwd_*_sel.
- Same-cycle WB write to an ID read is resolved by the write-first register file, not by this block.
- Counters, all saturating at all-ones:
  - stall_cycles += 1 each cycle pc_write=0.
  - flush_count += 1 each cycle flush=1.
- Reset values:
  - Outputs settle to pc_write=1, if_id_write=1, bubble=0, flush=0, mem_stall=0, sel=00, counters=0.
  - Reset asserted mid-stall clears wait_cnt and the records immediately (asynchronously).

Decomposition:
- Package rv32i_pipe_pkg holds:
  - FWD_REGFILE/FWD_EXMEM/FWD_MEMWB encodings.
  - The stage-record struct typedef.
  - REG_AW and XLEN defaults.
- One sub-module, rv32i_fwd_mux: selection comparators plus the 3:1 data mux. It is instantiated twice, once for A and once for B.

Test Plan:
- lw x5,0(x1); add x6,x5,x2 (LOAD_LATENCY=1) -> exactly one cycle pc_write=0, bubble=1; next cycle fwd_a_sel=01, ex_op_a=wb_data; stall_cycles=1.
- add x3,x1,x2; sub x4,x3,x3 -> fwd_a_sel=fwd_b_sel=10, ex_op_a=exmem_alu_result, no stall.
- addi x0,x0,5; add x7,x0,x0 with exmem_alu_result=5 -> sel stays 00, ex_op_a=ex_rs1_data.
- ex_branch_taken=1 while lu=1 -> flush=1, bubble=1, pc_write=1; flush_count=1.
- LOAD_LATENCY=3, lw followed by a taken beq in EX -> mem_stall high exactly 2 cycles with all enables 0 and flush 0; flush asserts the cycle after release.
- Drive reset=0 on the 2nd stall cycle (LOAD_LATENCY=4) -> mem_stall=0 and wait_cnt=0 without a clock edge; counters=0.
